audio_param_scheduler: RTL and testbench

AUDIO_PARAM_SCHEDULER -- requirements
Module: audio_param_scheduler

---
 rtl/audio_param_if.sv | 31 +++
 rtl/audio_param_scheduler.sv | 203 ++++++++++++++++++++
 tb/tb_audio_param_scheduler.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/audio_param_if.sv
// Parameter bus between the scheduler and the audio datapath.
// master: scheduler drives the live parameters; slave: datapath supplies ticks.
interface audio_param_if;
    logic               sample_tick;
    logic signed [15:0] gain;
    logic signed [31:0] threshold;
    logic [3:0]         mix;
    logic               disabled;
    logic               param_update;
    logic               pending;

    modport master (
        input  sample_tick,
        output gain,
        output threshold,
        output mix,
        output disabled,
        output param_update,
        output pending
    );

    modport slave (
        output sample_tick,
        input  gain,
        input  threshold,
        input  mix,
        input  disabled,
        input  param_update,
        input  pending
    );
endinterface

// File: rtl/audio_param_scheduler.sv
// Debounced pushbutton editing of shadow effect parameters, committed
// to the live outputs only on audio sample boundaries.
module audio_param_scheduler #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          key3,
    input  logic          key2,
    input  logic [9:0]    SW,
    audio_param_if.master bus
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic signed [15:0] GAIN_RST = 16'sd1;
    localparam logic signed [15:0] GAIN_MIN = 16'sd1;
    localparam logic signed [15:0] GAIN_MAX = 16'sd50;
    localparam logic signed [31:0] THR_RST  = 32'sd50;
    localparam logic signed [31:0] THR_MIN  = 32'sd20;
    localparam logic signed [31:0] THR_MAX  = 32'sd32000;
    localparam logic [3:0]         MIX_RST  = 4'd8;

    typedef enum logic [1:0] {
        RELEASED,
        DB_PRESS,
        PRESSED,
        DB_RELEASE
    } db_state_e;

    // Index 0 is key2 (increment), index 1 is key3 (decrement).
    logic [1:0]    sync1_q, sync1_d;
    logic [1:0]    sync2_q, sync2_d;
    db_state_e     db_q [2];
    db_state_e     db_d [2];
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];
    logic [1:0]    ev;

    logic signed [15:0] gain_sh_q, gain_sh_d, gain_q, gain_d;
    logic signed [31:0] thr_sh_q, thr_sh_d, thr_q, thr_d;
    logic [3:0]         mix_sh_q, mix_sh_d, mix_q, mix_d;
    logic               pending_q, pending_d;
    logic               update_q, update_d;
    logic               disabled_q, disabled_d;

    logic               inc, dec, commit;
    logic signed [31:0] up_step, dn_step, thr_up, thr_dn;
    logic               unused_sw;

    assign unused_sw = ^SW[8:4];

    always_comb begin
        sync1_d = {key3, key2};
        sync2_d = sync1_q;
        ev      = 2'b00;
        for (int k = 0; k < 2; k++) begin
            db_d[k]  = db_q[k];
            cnt_d[k] = cnt_q[k];
            unique case (db_q[k])
                RELEASED: begin
                    if (!sync2_q[k]) begin
                        db_d[k]  = DB_PRESS;
                        cnt_d[k] = '0;
                    end
                end
                DB_PRESS: begin
                    if (sync2_q[k]) begin
                        db_d[k]  = RELEASED;
                        cnt_d[k] = '0;
                    end else if (cnt_q[k] == CNT_MAX) begin
                        db_d[k]  = PRESSED;
                        cnt_d[k] = '0;
                        ev[k]    = 1'b1;
                    end else begin
                        cnt_d[k] = cnt_q[k] + 1'b1;
                    end
                end
                PRESSED: begin
                    if (sync2_q[k]) begin
                        db_d[k]  = DB_RELEASE;
                        cnt_d[k] = '0;
                    end
                end
                DB_RELEASE: begin
                    if (!sync2_q[k]) begin
                        db_d[k]  = PRESSED;
                        cnt_d[k] = '0;
                    end else if (cnt_q[k] == CNT_MAX) begin
                        db_d[k]  = RELEASED;
                        cnt_d[k] = '0;
                    end else begin
                        cnt_d[k] = cnt_q[k] + 1'b1;
                    end
                end
                default: begin
                    db_d[k]  = RELEASED;
                    cnt_d[k] = '0;
                end
            endcase
        end
    end

    // Step size grows with the threshold so the wide range stays reachable.
    always_comb begin
        if (thr_sh_q < 32'sd100)       up_step = 32'sd10;
        else if (thr_sh_q < 32'sd500)  up_step = 32'sd50;
        else if (thr_sh_q < 32'sd1000) up_step = 32'sd100;
        else                           up_step = 32'sd500;

        if (thr_sh_q <= 32'sd100)       dn_step = 32'sd10;
        else if (thr_sh_q <= 32'sd500)  dn_step = 32'sd50;
        else if (thr_sh_q <= 32'sd1000) dn_step = 32'sd100;
        else                            dn_step = 32'sd500;

        thr_up = thr_sh_q + up_step;
        if (thr_up > THR_MAX) thr_up = THR_MAX;
        thr_dn = thr_sh_q - dn_step;
        if (thr_dn < THR_MIN) thr_dn = THR_MIN;
    end

    always_comb begin
        inc       = ev[0];
        dec       = ev[1] & ~ev[0];
        gain_sh_d = gain_sh_q;
        thr_sh_d  = thr_sh_q;
        mix_sh_d  = mix_sh_q;
        case (SW[3:0])
            4'd0: begin
                if (inc)      thr_sh_d = thr_up;
                else if (dec) thr_sh_d = thr_dn;
            end
            4'd1: begin
                if (inc && gain_sh_q < GAIN_MAX)
                    gain_sh_d = gain_sh_q + 16'sd1;
                else if (dec && gain_sh_q > GAIN_MIN)
                    gain_sh_d = gain_sh_q - 16'sd1;
            end
            4'd2: begin
                if (inc && mix_sh_q != 4'd15)
                    mix_sh_d = mix_sh_q + 4'd1;
                else if (dec && mix_sh_q != 4'd0)
                    mix_sh_d = mix_sh_q - 4'd1;
            end
            default: ;
        endcase

        // Live side samples the pre-edit shadow, so a coincident edit waits a tick.
        commit     = bus.sample_tick & pending_q;
        gain_d     = commit ? gain_sh_q : gain_q;
        thr_d      = commit ? thr_sh_q : thr_q;
        mix_d      = commit ? mix_sh_q : mix_q;
        pending_d  = (gain_sh_d != gain_d) | (thr_sh_d != thr_d) |
                     (mix_sh_d != mix_d);
        update_d   = commit;
        disabled_d = ~SW[9];
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q    <= 2'b11;
            sync2_q    <= 2'b11;
            for (int k = 0; k < 2; k++) begin
                db_q[k]  <= RELEASED;
                cnt_q[k] <= '0;
            end
            gain_sh_q  <= GAIN_RST;
            thr_sh_q   <= THR_RST;
            mix_sh_q   <= MIX_RST;
            gain_q     <= GAIN_RST;
            thr_q      <= THR_RST;
            mix_q      <= MIX_RST;
            pending_q  <= 1'b0;
            update_q   <= 1'b0;
            disabled_q <= 1'b1;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            for (int k = 0; k < 2; k++) begin
                db_q[k]  <= db_d[k];
                cnt_q[k] <= cnt_d[k];
            end
            gain_sh_q  <= gain_sh_d;
            thr_sh_q   <= thr_sh_d;
            mix_sh_q   <= mix_sh_d;
            gain_q     <= gain_d;
            thr_q      <= thr_d;
            mix_q      <= mix_d;
            pending_q  <= pending_d;
            update_q   <= update_d;
            disabled_q <= disabled_d;
        end
    end

    assign bus.gain         = gain_q;
    assign bus.threshold    = thr_q;
    assign bus.mix          = mix_q;
    assign bus.disabled     = disabled_q;
    assign bus.param_update = update_q;
    assign bus.pending      = pending_q;

endmodule

// File: tb/tb_audio_param_scheduler.sv
// Directed bench for audio_param_scheduler with a short debounce window.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_audio_param_scheduler;

    logic       CLK   = 1'b0;
    logic       RST_N = 1'b0;
    logic       key2  = 1'b1;
    logic       key3  = 1'b1;
    logic [9:0] SW    = 10'h201;
    int         tests = 0;
    int         fails = 0;
    int         thr_exp [6] = '{60, 70, 80, 90, 100, 150};

    audio_param_if bus ();

    audio_param_scheduler #(.DEBOUNCE_CYCLES(4)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .key3  (key3),
        .key2  (key2),
        .SW    (SW),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Hold long enough to debounce the press, then long enough to release.
    task automatic press(input bit up, input bit dn);
        if (up) key2 = 1'b0;
        if (dn) key3 = 1'b0;
        cyc(10);
        key2 = 1'b1;
        key3 = 1'b1;
        cyc(8);
    endtask

    task automatic tick();
        bus.sample_tick = 1'b1;
        cyc(1);
        bus.sample_tick = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_gain"}, bus.gain, 1);
        chk({tag, "_thr"}, bus.threshold, 50);
        chk({tag, "_mix"}, bus.mix, 8);
        chk({tag, "_dis"}, bus.disabled, 1);
        chk({tag, "_pu"}, bus.param_update, 0);
        chk({tag, "_pend"}, bus.pending, 0);
    endtask

    initial begin
        bus.sample_tick = 1'b0;
        cyc(2);
        chk_reset("rst");
        RST_N = 1'b1;
        chk("dis_at_release", bus.disabled, 1);
        cyc(1);
        chk("dis_enabled", bus.disabled, 0);

        // gain 1 -> 2 held until a tick
        press(1, 0);
        chk("g_pend", bus.pending, 1);
        chk("g_pre", bus.gain, 1);
        cyc(5);
        chk("g_hold", bus.gain, 1);
        tick();
        chk("g_post", bus.gain, 2);
        chk("g_pu", bus.param_update, 1);
        cyc(1);
        chk("g_pu_off", bus.param_update, 0);
        chk("g_pend_off", bus.pending, 0);

        // bouncing key never completes a press
        key2 = 1'b0; cyc(3);
        key2 = 1'b1; cyc(1);
        key2 = 1'b0; cyc(3);
        key2 = 1'b1; cyc(10);
        chk("bnc_pend", bus.pending, 0);
        tick();
        chk("bnc_pu", bus.param_update, 0);
        chk("bnc_gain", bus.gain, 2);

        // threshold step schedule upward, then down to the floor
        SW = 10'h200;
        for (int i = 0; i < 6; i++) begin
            press(1, 0);
            tick();
            chk($sformatf("thr_up%0d", i), bus.threshold, thr_exp[i]);
        end
        repeat (9) begin
            press(0, 1);
            tick();
        end
        chk("thr_floor", bus.threshold, 20);
        press(0, 1);
        chk("thr_min_pend", bus.pending, 0);
        tick();
        chk("thr_min", bus.threshold, 20);

        // saturation of gain and mix
        SW = 10'h201;
        repeat (60) press(1, 0);
        tick();
        chk("gain_sat", bus.gain, 50);
        press(1, 0);
        chk("gain_sat_pend", bus.pending, 0);
        SW = 10'h202;
        repeat (10) press(0, 1);
        tick();
        chk("mix_sat", bus.mix, 0);

        // unused selector discards events
        SW = 10'h203;
        press(1, 0);
        press(0, 1);
        chk("sel3_pend", bus.pending, 0);

        // simultaneous presses: increment wins
        RST_N = 1'b0; cyc(2); RST_N = 1'b1;
        SW = 10'h201;
        cyc(1);
        repeat (4) press(1, 0);
        tick();
        chk("sim_base", bus.gain, 5);
        press(1, 1);
        chk("sim_pend", bus.pending, 1);
        tick();
        chk("sim_gain", bus.gain, 6);

        // press event lands on the committing tick edge
        SW = 10'h202;
        press(0, 1);
        chk("co_pend0", bus.pending, 1);
        SW = 10'h201;
        key2 = 1'b0;
        cyc(6);
        bus.sample_tick = 1'b1;
        cyc(1);
        bus.sample_tick = 1'b0;
        chk("co_mix", bus.mix, 7);
        chk("co_gain", bus.gain, 6);
        chk("co_pu", bus.param_update, 1);
        chk("co_pend", bus.pending, 1);
        key2 = 1'b1;
        cyc(8);
        tick();
        chk("co_next", bus.gain, 7);

        // reset in the middle of a press
        key2 = 1'b0;
        cyc(4);
        RST_N = 1'b0;
        #1;
        chk("async_gain", bus.gain, 1);
        key2 = 1'b1;
        cyc(2);
        chk_reset("midrst");
        RST_N = 1'b1;
        chk("mr_dis_hold", bus.disabled, 1);
        cyc(1);
        chk("mr_dis_run", bus.disabled, 0);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("mr_pu%0d", i), bus.param_update, 0);
            chk($sformatf("mr_pend%0d", i), bus.pending, 0);
            cyc(1);
        end
        tick();
        chk("mr_gain", bus.gain, 1);
        chk("mr_pu_tick", bus.param_update, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
